// File: rtl/phase_gen_pkg.sv
// Shared definitions for the phase-shifted square-wave generator:
// controller state encoding and the default counter width.
package phase_gen_pkg;

   localparam int CNT_W_DEF = 32;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } gen_state_e;

endpackage

// File: rtl/phase_cfg_regs.sv
// Configuration front end: validates offered configs, holds the active and
// pending register sets, and drives the ready/error handshake signals.
module phase_cfg_regs
   import phase_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             run_i,
   input  logic             apply_i,
   input  logic             cfg_valid_i,
   input  logic [CNT_W-1:0] cfg_period_i,
   input  logic [CNT_W-1:0] cfg_high_i,
   input  logic [CNT_W-1:0] cfg_delay_i,
   output logic             cfg_ready_o,
   output logic             cfg_err_o,
   output logic             cfg_loaded_o,
   output logic [CNT_W-1:0] act_period_o,
   output logic [CNT_W-1:0] act_high_o,
   output logic [CNT_W-1:0] act_delay_o
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

   logic [CNT_W-1:0] act_period_q, act_period_d;
   logic [CNT_W-1:0] act_high_q,   act_high_d;
   logic [CNT_W-1:0] act_delay_q,  act_delay_d;
   logic [CNT_W-1:0] pend_period_q, pend_period_d;
   logic [CNT_W-1:0] pend_high_q,   pend_high_d;
   logic [CNT_W-1:0] pend_delay_q,  pend_delay_d;
   logic             pend_valid_q, pend_valid_d;
   logic             cfg_loaded_q, cfg_loaded_d;
   logic             cfg_err_q,    cfg_err_d;
   logic             xfer_s;
   logic             cfg_ok_s;

   // A transfer can never coincide with a pending apply: ready is low whenever
   // something is pending, so the old pending set is never overwritten.
   assign xfer_s   = cfg_valid_i && !pend_valid_q;
   assign cfg_ok_s = (cfg_period_i >= TWO) && (cfg_high_i >= ONE) &&
                     (cfg_high_i < cfg_period_i) && (cfg_delay_i < cfg_period_i);

   // Next-state logic for the active/pending register sets and flags.
   always_comb begin
      act_period_d  = act_period_q;
      act_high_d    = act_high_q;
      act_delay_d   = act_delay_q;
      pend_period_d = pend_period_q;
      pend_high_d   = pend_high_q;
      pend_delay_d  = pend_delay_q;
      pend_valid_d  = pend_valid_q;
      cfg_loaded_d  = cfg_loaded_q;
      cfg_err_d     = 1'b0;

      if (apply_i && pend_valid_q) begin
         act_period_d = pend_period_q;
         act_high_d   = pend_high_q;
         act_delay_d  = pend_delay_q;
         pend_valid_d = 1'b0;
      end else begin
         pend_valid_d = pend_valid_q;
      end

      if (xfer_s) begin
         if (!cfg_ok_s) begin
            cfg_err_d = 1'b1;
         end else if (!run_i) begin
            act_period_d = cfg_period_i;
            act_high_d   = cfg_high_i;
            act_delay_d  = cfg_delay_i;
            cfg_loaded_d = 1'b1;
         end else begin
            pend_period_d = cfg_period_i;
            pend_high_d   = cfg_high_i;
            pend_delay_d  = cfg_delay_i;
            pend_valid_d  = 1'b1;
         end
      end else begin
         cfg_err_d = 1'b0;
      end
   end

   // Configuration state registers.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         act_period_q  <= '0;
         act_high_q    <= '0;
         act_delay_q   <= '0;
         pend_period_q <= '0;
         pend_high_q   <= '0;
         pend_delay_q  <= '0;
         pend_valid_q  <= 1'b0;
         cfg_loaded_q  <= 1'b0;
         cfg_err_q     <= 1'b0;
      end else begin
         act_period_q  <= act_period_d;
         act_high_q    <= act_high_d;
         act_delay_q   <= act_delay_d;
         pend_period_q <= pend_period_d;
         pend_high_q   <= pend_high_d;
         pend_delay_q  <= pend_delay_d;
         pend_valid_q  <= pend_valid_d;
         cfg_loaded_q  <= cfg_loaded_d;
         cfg_err_q     <= cfg_err_d;
      end
   end

   assign cfg_ready_o  = !pend_valid_q;
   assign cfg_err_o    = cfg_err_q;
   assign cfg_loaded_o = cfg_loaded_q;
   assign act_period_o = act_period_q;
   assign act_high_o   = act_high_q;
   assign act_delay_o  = act_delay_q;

endmodule

// File: rtl/phase_shift_gen.sv
// Two square waves of common period/high time, the second lagging the first
// by a programmable number of cycles; counters and run control live here.
module phase_shift_gen
   import phase_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [CNT_W-1:0] cfg_delay,
   output logic             sig_out0,
   output logic             sig_out1,
   output logic             period_tick,
   output logic             cfg_err
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   gen_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_s;
   logic             sig0_q, sig0_d;
   logic             sig1_q, sig1_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] act_period_s;
   logic [CNT_W-1:0] act_high_s;
   logic [CNT_W-1:0] act_delay_s;
   logic             cfg_loaded_s;
   logic             run_s;
   logic             wrap_s;
   logic             apply_s;

   assign run_s   = (state_q == ST_RUN);
   assign wrap_s  = (cnt0_q == (act_period_s - ONE));
   assign apply_s = run_s && wrap_s;

   phase_cfg_regs #(
      .CNT_W (CNT_W)
   ) u_cfg (
      .sys_clk      (sys_clk),
      .rst_n        (rst_n),
      .run_i        (run_s),
      .apply_i      (apply_s),
      .cfg_valid_i  (cfg_valid),
      .cfg_period_i (cfg_period),
      .cfg_high_i   (cfg_high),
      .cfg_delay_i  (cfg_delay),
      .cfg_ready_o  (cfg_ready),
      .cfg_err_o    (cfg_err),
      .cfg_loaded_o (cfg_loaded_s),
      .act_period_o (act_period_s),
      .act_high_o   (act_high_s),
      .act_delay_o  (act_delay_s)
   );

   // Run control and reference phase counter.
   always_comb begin
      state_d = state_q;
      cnt0_d  = '0;
      case (state_q)
         ST_IDLE: begin
            cnt0_d = '0;
            if (enable && cfg_loaded_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_IDLE;
               cnt0_d  = '0;
            end else begin
               state_d = ST_RUN;
               cnt0_d  = wrap_s ? '0 : (cnt0_q + ONE);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt0_d  = '0;
         end
      endcase
   end

   // Lagged phase: delay < period keeps both terms below period, so no carry out.
   always_comb begin
      cnt1_s = '0;
      if (cnt0_q >= act_delay_s) begin
         cnt1_s = cnt0_q - act_delay_s;
      end else begin
         cnt1_s = cnt0_q + (act_period_s - act_delay_s);
      end
   end

   // Output decode, one cycle behind the counter.
   always_comb begin
      sig0_d = run_s && (cnt0_q < act_high_s);
      sig1_d = run_s && (cnt1_s < act_high_s);
      tick_d = sig0_d && !sig0_q;
   end

   // Controller and output registers.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt0_q  <= '0;
         sig0_q  <= 1'b0;
         sig1_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt0_q  <= cnt0_d;
         sig0_q  <= sig0_d;
         sig1_q  <= sig1_d;
         tick_q  <= tick_d;
      end
   end

   assign sig_out0    = sig0_q;
   assign sig_out1    = sig1_q;
   assign period_tick = tick_q;

endmodule

// File: tb/tb_phase_shift_gen.sv
// Directed, table-driven bench for phase_shift_gen: per-config expected
// waveforms are bit masks indexed by the reference phase.
module tb_phase_shift_gen;

   logic        sys_clk;
   logic        rst_n;
   logic        enable;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_period;
   logic [31:0] cfg_high;
   logic [31:0] cfg_delay;
   logic        sig_out0;
   logic        sig_out1;
   logic        period_tick;
   logic        cfg_err;

   typedef struct {
      logic [31:0] period;
      logic [31:0] high;
      logic [31:0] delay;
      logic [31:0] m0;
      logic [31:0] m1;
      logic [31:0] mt;
   } vec_t;

   vec_t vecs [0:6];
   int   n_checks;
   int   n_pass;
   int   cur;
   int   j_g;

   phase_shift_gen #(.CNT_W(32)) dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_period  (cfg_period),
      .cfg_high    (cfg_high),
      .cfg_delay   (cfg_delay),
      .sig_out0    (sig_out0),
      .sig_out1    (sig_out1),
      .period_tick (period_tick),
      .cfg_err     (cfg_err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s vec=%0d j=%0d: got %0b expected %0b", name, cur, j_g, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      rst_n     = 1'b0;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      @(negedge sys_clk);
      rst_n     = 1'b1;
   endtask

   task automatic drive_cfg(input logic [31:0] p, input logic [31:0] h, input logic [31:0] d);
      cfg_valid  = 1'b1;
      cfg_period = p;
      cfg_high   = h;
      cfg_delay  = d;
   endtask

   // Load a table entry from IDLE and start it; next edge shows phase 0.
   task automatic load(input int idx);
      @(negedge sys_clk);
      drive_cfg(vecs[idx].period, vecs[idx].high, vecs[idx].delay);
      enable = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      cfg_valid = 1'b0;
      @(posedge sys_clk);
      cur = idx;
      j_g = 0;
   endtask

   task automatic run_cycles(input int n);
      int e;
      for (int k = 0; k < n; k++) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         e = j_g % int'(vecs[cur].period);
         chk("sig_out0", sig_out0, vecs[cur].m0[e]);
         chk("sig_out1", sig_out1, vecs[cur].m1[e]);
         chk("period_tick", period_tick, vecs[cur].mt[e]);
         j_g++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'd10, 32'd5, 32'd0, 32'h0000_001F, 32'h0000_001F, 32'h0000_0001};
      vecs[1] = '{32'd10, 32'd5, 32'd3, 32'h0000_001F, 32'h0000_00F8, 32'h0000_0001};
      vecs[2] = '{32'd10, 32'd4, 32'd9, 32'h0000_000F, 32'h0000_0207, 32'h0000_0001};
      vecs[3] = '{32'd4,  32'd1, 32'd2, 32'h0000_0001, 32'h0000_0004, 32'h0000_0001};
      vecs[4] = '{32'd2,  32'd1, 32'd1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001};
      vecs[5] = '{32'd10, 32'd9, 32'd5, 32'h0000_01FF, 32'h0000_03EF, 32'h0000_0001};
      vecs[6] = '{32'd20, 32'd5, 32'd0, 32'h0000_001F, 32'h0000_001F, 32'h0000_0001};
      n_checks   = 0;
      n_pass     = 0;
      cur        = 0;
      j_g        = 0;
      rst_n      = 1'b0;
      enable     = 1'b0;
      cfg_valid  = 1'b0;
      cfg_period = 32'd0;
      cfg_high   = 32'd0;
      cfg_delay  = 32'd0;

      // Reset values
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst_sig_out0", sig_out0, 1'b0);
      chk("rst_sig_out1", sig_out1, 1'b0);
      chk("rst_tick", period_tick, 1'b0);
      chk("rst_cfg_err", cfg_err, 1'b0);
      chk("rst_cfg_ready", cfg_ready, 1'b1);
      rst_n = 1'b1;

      // Table: each config from a clean reset, two full periods
      for (int v = 0; v < 7; v++) begin
         do_reset();
         load(v);
         run_cycles(2 * int'(vecs[v].period));
      end

      // Rejected configs leave the running waveform untouched
      do_reset();
      load(1);
      run_cycles(12);
      drive_cfg(32'd10, 32'd0, 32'd3);
      run_cycles(1);
      cfg_valid = 1'b0;
      chk("err_high0_pulse", cfg_err, 1'b1);
      chk("err_high0_ready", cfg_ready, 1'b1);
      run_cycles(1);
      chk("err_high0_clear", cfg_err, 1'b0);
      drive_cfg(32'd10, 32'd5, 32'd10);
      run_cycles(1);
      cfg_valid = 1'b0;
      chk("err_delay10_pulse", cfg_err, 1'b1);
      run_cycles(1);
      chk("err_delay10_clear", cfg_err, 1'b0);
      run_cycles(16);

      // Mid-run period change offered at cnt0=4, applied at the wrap
      do_reset();
      load(0);
      run_cycles(4);
      chk("chg_ready_before", cfg_ready, 1'b1);
      drive_cfg(vecs[6].period, vecs[6].high, vecs[6].delay);
      run_cycles(1);
      cfg_valid = 1'b0;
      chk("chg_ready_low", cfg_ready, 1'b0);
      for (int k = 0; k < 4; k++) begin
         run_cycles(1);
         chk("chg_ready_low", cfg_ready, 1'b0);
      end
      run_cycles(1);
      chk("chg_ready_back", cfg_ready, 1'b1);
      cur = 6;
      j_g = 0;
      run_cycles(40);

      // Asynchronous reset at cnt0=6, then no run until a fresh config
      do_reset();
      load(1);
      run_cycles(6);
      #1 rst_n = 1'b0;
      #1;
      chk("async_sig_out0", sig_out0, 1'b0);
      chk("async_sig_out1", sig_out1, 1'b0);
      chk("async_tick", period_tick, 1'b0);
      chk("async_ready", cfg_ready, 1'b1);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         chk("idle_sig_out0", sig_out0, 1'b0);
         chk("idle_sig_out1", sig_out1, 1'b0);
         chk("idle_tick", period_tick, 1'b0);
      end
      load(0);
      run_cycles(20);

      // Dropping enable returns the outputs low
      enable = 1'b0;
      @(posedge sys_clk);
      @(posedge sys_clk);
      for (int k = 0; k < 12; k++) begin
         @(negedge sys_clk);
         chk("disable_sig_out0", sig_out0, 1'b0);
         chk("disable_sig_out1", sig_out1, 1'b0);
         @(posedge sys_clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
